// File: rtl/seq_divide.sv
// rtl/seq_divide.sv - multi-cycle restoring unsigned divider with start/done handshake
//
// Computes q = a / b and r = a % b over WIDTH-bit unsigned operands,
// resolving RADIX_BITS quotient bits per clock (N = WIDTH/RADIX_BITS
// iteration edges after the accepting edge). Divide-by-zero completes in
// one edge with q = all-ones, r = a, dz = 1.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled only while ready = 1
//   a      in   dividend, captured on an accepted start
//   b      in   divisor, captured on an accepted start
//   ready  out  block can accept start (IDLE or DONE)
//   done   out  one-cycle pulse, q/r/dz valid
//   q      out  quotient (held until the next operation completes)
//   r      out  remainder (held until the next operation completes)
//   dz     out  divide-by-zero flag for the current result

module seq_divide #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    localparam int N  = WIDTH / RADIX_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!((RADIX_BITS == 1 || RADIX_BITS == 2 || RADIX_BITS == 4) &&
              (WIDTH > 0) && (WIDTH % RADIX_BITS == 0))) begin : g_bad_params
            $error("seq_divide: RADIX_BITS must be 1, 2 or 4 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;      // partial remainder, always < b between edges
    logic [WIDTH-1:0] sh;       // dividend bits shift out of the top, quotient bits shift in at the bottom
    logic [WIDTH-1:0] b_reg;

    logic             accept;
    logic             last_iter;

    logic [WIDTH:0]   ext;      // one extra bit so {rem, bit} >= b never overflows
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] sh_step;

    assign accept    = start && (state != RUN);
    assign last_iter = (cnt == CW'(N - 1));

    // RADIX_BITS restoring steps per clock, MSB first
    always_comb begin
        rem_step = rem;
        sh_step  = sh;
        ext      = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            ext     = {rem_step, sh_step[WIDTH-1]};
            sh_step = sh_step << 1;
            if (ext >= {1'b0, b_reg}) begin
                ext        = ext - {1'b0, b_reg};
                sh_step[0] = 1'b1;
            end
            rem_step = ext[WIDTH-1:0];
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (b == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        ready = 1'b1;
        done  = 1'b0;
        case (state)
            RUN:     ready = 1'b0;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

    // datapath and result registers; results only move on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            rem   <= '0;
            sh    <= '0;
            b_reg <= '0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            sh    <= a;
            b_reg <= b;
            if (b == '0) begin
                q  <= '1;
                r  <= a;
                dz <= 1'b1;
            end
        end else if (state == RUN) begin
            cnt <= cnt + CW'(1);
            rem <= rem_step;
            sh  <= sh_step;
            if (last_iter) begin
                q  <= sh_step;
                r  <= rem_step;
                dz <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divide.sv
// tb/tb_seq_divide.sv - directed and invariant bench for seq_divide

module tb_seq_divide;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a, b, q, r;
    logic        ready, done, dz;

    logic        start_w;
    logic [31:0] a_w, b_w, q_w, r_w;
    logic        ready_w, done_w, dz_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_divide #(.WIDTH(8), .RADIX_BITS(1)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ready(ready), .done(done), .q(q), .r(r), .dz(dz)
    );

    seq_divide #(.WIDTH(32), .RADIX_BITS(4)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .a(a_w), .b(b_w),
        .ready(ready_w), .done(done_w), .q(q_w), .r(r_w), .dz(dz_w)
    );

    // start one narrow op; lat = edges from the accepting edge until done is seen
    task automatic launch(input logic [7:0] av, input logic [7:0] bv, output int lat);
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 8'hC3; b = 8'h3C;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start_w = 1'b0; a_w = '0; b_w = '0;
        repeat (2) @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (q !== 8'd0 || r !== 8'd0) begin bad++; $display("FAIL reset_qr got=%0d/%0d want=0/0", q, r); end
        total++; if (dz !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", dz); end
        total++; if (ready_w !== 1'b1 || done_w !== 1'b0) begin bad++; $display("FAIL reset_wide got=%b%b want=10", ready_w, done_w); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        int ready_hi;
        @(negedge clk);
        start = 1'b1; a = 8'd100; b = 8'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1; ready_hi = 0;
        while (!done && lat < 40) begin
            if (ready) ready_hi++;
            @(negedge clk);
            lat++;
        end
        total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", lat); end
        total++; if (ready_hi !== 0) begin bad++; $display("FAIL basic_ready_in_run got=%0d want=0", ready_hi); end
        total++; if (q !== 8'd14 || r !== 8'd2 || dz !== 1'b0) begin bad++; $display("FAIL basic_result got=%0d/%0d/%b want=14/2/0", q, r, dz); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL basic_ready_at_done got=%b want=1", ready); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_pulse_width got=%b want=0", done); end
        total++; if (q !== 8'd14 || r !== 8'd2) begin bad++; $display("FAIL basic_hold got=%0d/%0d want=14/2", q, r); end
    endtask

    task automatic test_div_zero();
        int lat;
        launch(8'h5A, 8'h00, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", lat); end
        total++; if (q !== 8'hFF || r !== 8'h5A || dz !== 1'b1) begin bad++; $display("FAIL dz_result got=%h/%h/%b want=ff/5a/1", q, r, dz); end
        launch(8'h5A, 8'h5A, lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL eq_latency got=%0d want=9", lat); end
        total++; if (q !== 8'd1 || r !== 8'd0 || dz !== 1'b0) begin bad++; $display("FAIL eq_result got=%0d/%0d/%b want=1/0/0", q, r, dz); end
    endtask

    task automatic test_boundaries();
        int lat;
        launch(8'd3, 8'd200, lat);
        total++; if (q !== 8'd0 || r !== 8'd3) begin bad++; $display("FAIL a_lt_b got=%0d/%0d want=0/3", q, r); end
        launch(8'd255, 8'd1, lat);
        total++; if (q !== 8'd255 || r !== 8'd0) begin bad++; $display("FAIL b_one got=%0d/%0d want=255/0", q, r); end
        launch(8'd0, 8'd5, lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL a_zero_latency got=%0d want=9", lat); end
        total++; if (q !== 8'd0 || r !== 8'd0) begin bad++; $display("FAIL a_zero got=%0d/%0d want=0/0", q, r); end
        launch(8'd255, 8'd255, lat);
        total++; if (q !== 8'd1 || r !== 8'd0) begin bad++; $display("FAIL max_eq got=%0d/%0d want=1/0", q, r); end
        launch(8'd254, 8'd255, lat);
        total++; if (q !== 8'd0 || r !== 8'd254) begin bad++; $display("FAIL max_lt got=%0d/%0d want=0/254", q, r); end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        @(negedge clk);
        start = 1'b1; a = 8'd255; b = 8'd16;
        @(posedge clk);
        @(negedge clk);
        a = 8'd17; b = 8'd255;   // start stays high through RUN and DONE
        lat1 = 1;
        while (!done && lat1 < 40) begin
            @(negedge clk);
            lat1++;
        end
        total++; if (lat1 !== 9) begin bad++; $display("FAIL b2b_first_latency got=%0d want=9", lat1); end
        total++; if (q !== 8'd15 || r !== 8'd15) begin bad++; $display("FAIL b2b_first got=%0d/%0d want=15/15", q, r); end
        @(negedge clk);
        start = 1'b0;
        total++; if (ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL b2b_no_idle got=%b%b want=00", ready, done); end
        lat2 = 1;
        while (!done && lat2 < 40) begin
            @(negedge clk);
            lat2++;
        end
        total++; if (lat2 !== 9) begin bad++; $display("FAIL b2b_spacing got=%0d want=9", lat2); end
        total++; if (q !== 8'd0 || r !== 8'd17) begin bad++; $display("FAIL b2b_second got=%0d/%0d want=0/17", q, r); end
    endtask

    task automatic test_start_during_run();
        int lat;
        @(negedge clk);
        start = 1'b1; a = 8'd200; b = 8'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (2) begin @(negedge clk); lat++; end
        start = 1'b1; a = 8'd50; b = 8'd7;
        @(negedge clk); lat++;
        start = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++; if (lat !== 9) begin bad++; $display("FAIL ignore_latency got=%0d want=9", lat); end
        total++; if (q !== 8'd66 || r !== 8'd2) begin bad++; $display("FAIL ignore_result got=%0d/%0d want=66/2", q, r); end
    endtask

    task automatic test_mid_reset();
        int lat;
        int seen;
        @(negedge clk);
        start = 1'b1; a = 8'd100; b = 8'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got=%b%b want=10", ready, done); end
        total++; if (q !== 8'd0 || r !== 8'd0 || dz !== 1'b0) begin bad++; $display("FAIL midrst_out got=%0d/%0d/%b want=0/0/0", q, r, dz); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", seen); end
        launch(8'd9, 8'd4, lat);
        total++; if (lat !== 9 || q !== 8'd2 || r !== 8'd1) begin bad++; $display("FAIL midrst_after got=%0d/%0d lat=%0d want=2/1 lat=9", q, r, lat); end
    endtask

    task automatic test_wide_random();
        logic [31:0] av, bv;
        logic [63:0] recon;
        int lat;
        for (int i = 0; i < 2000; i++) begin
            case (i % 5)
                0:       av = 32'd0;
                1:       av = 32'd1;
                2:       av = 32'hFFFF_FFFF;
                default: av = $urandom;
            endcase
            case ((i / 5) % 6)
                0:       bv = 32'd1;
                1:       bv = 32'hFFFF_FFFF;
                2:       bv = 32'd0;
                3:       bv = 32'($urandom_range(1, 255));
                default: bv = $urandom;
            endcase
            @(negedge clk);
            start_w = 1'b1; a_w = av; b_w = bv;
            @(posedge clk);
            @(negedge clk);
            start_w = 1'b0; a_w = $urandom; b_w = $urandom;
            lat = 1;
            while (!done_w && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            if (bv == 32'd0) begin
                total++; if (lat !== 1) begin bad++; $display("FAIL wide_dz_latency i=%0d got=%0d want=1", i, lat); end
                total++; if (dz_w !== 1'b1 || q_w !== 32'hFFFF_FFFF || r_w !== av) begin bad++; $display("FAIL wide_dz i=%0d got=%h/%h/%b want=ffffffff/%h/1", i, q_w, r_w, dz_w, av); end
            end else begin
                recon = {32'd0, q_w} * {32'd0, bv} + {32'd0, r_w};
                total++; if (lat !== 9) begin bad++; $display("FAIL wide_latency i=%0d got=%0d want=9", i, lat); end
                total++;
                if (recon !== {32'd0, av} || !(r_w < bv) || dz_w !== 1'b0) begin
                    bad++;
                    $display("FAIL wide_invariant i=%0d a=%h b=%h got q=%h r=%h dz=%b want q*b+r=a r<b dz=0", i, av, bv, q_w, r_w, dz_w);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundaries();
        test_back_to_back();
        test_start_during_run();
        test_mid_reset();
        test_wide_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
